tri_meas: RTL and testbench

Waveform measurement block: the receiving end of the triangle/trapezoid sample stream produced by the team's triangle generator. Consumes one 9-bit sample per valid cycle, locks onto the rise/hold/fall pattern, and reports per-period peak, trough, segment lengths and total period. Flags any sample step that breaks the pattern. Sits downstream of the generator, or of any DAC-model source, in the waveform lessons testbenches.

---
 rtl/tri_pkg.sv | 32 +++
 rtl/tri_step_class.sv | 38 +++
 rtl/tri_meas.sv | 240 ++++++++++++++++++++++++
 tb/tb_tri_meas.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tri_pkg
// Description : Shared definitions for the triangle/trapezoid measurement
//               block: FSM state encoding, step-class encoding and default
//               sample / counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package tri_pkg;

    localparam int c_TRI_DW = 9;    // default sample width
    localparam int c_TRI_CW = 16;   // default length-counter width

    // Measurement FSM states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_ARM  = 3'd1,
        ST_RISE = 3'd2,
        ST_HOLD = 3'd3,
        ST_FALL = 3'd4
    } tri_state_e;

    // Classification of one sample step (d_in - prev)
    typedef enum logic [1:0] {
        CL_UP   = 2'd0,
        CL_FLAT = 2'd1,
        CL_DOWN = 2'd2,
        CL_BAD  = 2'd3
    } tri_class_e;

endpackage
`default_nettype wire

// File: rtl/tri_step_class.sv
`default_nettype none
// ============================================================================
// Module      : tri_step_class
// Description : Combinational step classifier. Computes d_in - prev as a
//               DW+1 bit two's-complement value and maps it to UP (+1),
//               FLAT (0), DOWN (-1) or BAD (any other step, incl. wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tri_step_class
    import tri_pkg::*;
#(
    parameter int DW = c_TRI_DW
)
(
    input  logic [DW-1:0] i_d_in,
    input  logic [DW-1:0] i_prev,
    output tri_class_e    o_class
);

    // Extra top bit keeps wrap-around steps (e.g. max -> 0) distinct from +/-1
    logic [DW:0] w_delta;

    assign w_delta = {1'b0, i_d_in} - {1'b0, i_prev};

    // Map the signed step onto its class; anything not +1/0/-1 is BAD
    always_comb begin
        o_class = CL_BAD;
        if (w_delta == {{DW{1'b0}}, 1'b1}) begin
            o_class = CL_UP;
        end else if (w_delta == '0) begin
            o_class = CL_FLAT;
        end else if (w_delta == '1) begin
            o_class = CL_DOWN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tri_meas.sv
`default_nettype none
// ============================================================================
// Module      : tri_meas
// Description : Waveform measurement for triangle/trapezoid sample streams.
//               Locks onto the rise/hold/fall pattern, publishes peak,
//               trough, segment lengths and period once per period, and
//               flags / counts any step that breaks the pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_meas
    import tri_pkg::*;
#(
    parameter int DW = c_TRI_DW,
    parameter int CW = c_TRI_CW
)
(
    input  logic          clk,
    input  logic          res,
    input  logic          in_vld,
    input  logic [DW-1:0] d_in,
    output logic          locked,
    output logic          meas_vld,
    output logic [DW-1:0] peak,
    output logic [DW-1:0] trough,
    output logic [CW-1:0] rise_len,
    output logic [CW-1:0] hold_len,
    output logic [CW-1:0] fall_len,
    output logic [CW-1:0] period_len,
    output logic          err,
    output logic [7:0]    err_cnt
);

    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
    localparam logic [CW-1:0] c_CNT_MAX = '1;

    tri_state_e    r_state;
    tri_state_e    w_state_nxt;
    tri_class_e    w_class;

    logic [DW-1:0] r_prev;
    logic          r_primed;      // a sample has been seen since reset
    logic [CW-1:0] r_rise;
    logic [CW-1:0] r_hold;
    logic [CW-1:0] r_fall;
    logic [DW-1:0] r_peak_c;      // peak candidate of the period in progress
    logic [DW-1:0] r_trough_c;    // trough candidate of the period in progress

    logic [CW-1:0] w_rise_nxt;
    logic [CW-1:0] w_hold_nxt;
    logic [CW-1:0] w_fall_nxt;
    logic [DW-1:0] w_peak_c_nxt;
    logic [DW-1:0] w_trough_c_nxt;
    logic [CW-1:0] w_period;
    logic          w_publish;
    logic          w_viol;

    logic          r_meas;
    logic          r_err;
    logic [7:0]    r_err_cnt;
    logic [DW-1:0] r_peak;
    logic [DW-1:0] r_trough;
    logic [CW-1:0] r_rise_len;
    logic [CW-1:0] r_hold_len;
    logic [CW-1:0] r_fall_len;
    logic [CW-1:0] r_period_len;

    tri_step_class #(
        .DW (DW)
    ) u_step_class (
        .i_d_in  (d_in),
        .i_prev  (r_prev),
        .o_class (w_class)
    );

    assign w_period = r_rise + r_hold + r_fall;

    // State register
    always_ff @(posedge clk) begin
        if (!res) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter updates, publish and violation decisions
    always_comb begin
        w_state_nxt    = r_state;
        w_rise_nxt     = r_rise;
        w_hold_nxt     = r_hold;
        w_fall_nxt     = r_fall;
        w_peak_c_nxt   = r_peak_c;
        w_trough_c_nxt = r_trough_c;
        w_publish      = 1'b0;
        w_viol         = 1'b0;
        // The very first sample after reset has no predecessor to compare to
        if (in_vld && r_primed) begin
            case (r_state)
                ST_SYNC: begin
                    if (w_class == CL_DOWN) begin
                        w_state_nxt = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (w_class == CL_UP) begin
                        w_state_nxt    = ST_RISE;
                        w_trough_c_nxt = r_prev;
                        w_rise_nxt     = c_CNT_ONE;
                        w_hold_nxt     = '0;
                        w_fall_nxt     = '0;
                    end else if (w_class == CL_BAD) begin
                        w_state_nxt = ST_SYNC;
                    end
                end
                ST_RISE: begin
                    case (w_class)
                        CL_UP: begin
                            if (r_rise == c_CNT_MAX) begin
                                w_viol = 1'b1;
                            end else begin
                                w_rise_nxt = r_rise + c_CNT_ONE;
                            end
                        end
                        CL_FLAT: begin
                            w_state_nxt  = ST_HOLD;
                            w_hold_nxt   = c_CNT_ONE;
                            w_peak_c_nxt = r_prev;
                        end
                        CL_DOWN: begin
                            w_state_nxt  = ST_FALL;
                            w_hold_nxt   = '0;
                            w_fall_nxt   = c_CNT_ONE;
                            w_peak_c_nxt = r_prev;
                        end
                        default: w_viol = 1'b1;
                    endcase
                end
                ST_HOLD: begin
                    case (w_class)
                        CL_FLAT: begin
                            if (r_hold == c_CNT_MAX) begin
                                w_viol = 1'b1;
                            end else begin
                                w_hold_nxt = r_hold + c_CNT_ONE;
                            end
                        end
                        CL_DOWN: begin
                            w_state_nxt = ST_FALL;
                            w_fall_nxt  = c_CNT_ONE;
                        end
                        default: w_viol = 1'b1;
                    endcase
                end
                ST_FALL: begin
                    case (w_class)
                        CL_DOWN: begin
                            if (r_fall == c_CNT_MAX) begin
                                w_viol = 1'b1;
                            end else begin
                                w_fall_nxt = r_fall + c_CNT_ONE;
                            end
                        end
                        CL_UP: begin
                            // Period closes; the current sample starts the next rise
                            w_publish      = 1'b1;
                            w_state_nxt    = ST_RISE;
                            w_trough_c_nxt = r_prev;
                            w_rise_nxt     = c_CNT_ONE;
                            w_hold_nxt     = '0;
                            w_fall_nxt     = '0;
                        end
                        default: w_viol = 1'b1;
                    endcase
                end
                default: w_state_nxt = ST_SYNC;
            endcase
            if (w_viol) begin
                w_state_nxt = ST_SYNC;
            end
        end
    end

    // Sample history, running counters, published results and error counter
    always_ff @(posedge clk) begin
        if (!res) begin
            r_prev       <= '0;
            r_primed     <= 1'b0;
            r_rise       <= '0;
            r_hold       <= '0;
            r_fall       <= '0;
            r_peak_c     <= '0;
            r_trough_c   <= '0;
            r_meas       <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            r_peak       <= '0;
            r_trough     <= '0;
            r_rise_len   <= '0;
            r_hold_len   <= '0;
            r_fall_len   <= '0;
            r_period_len <= '0;
        end else begin
            if (in_vld) begin
                r_prev   <= d_in;
                r_primed <= 1'b1;
            end
            r_rise     <= w_rise_nxt;
            r_hold     <= w_hold_nxt;
            r_fall     <= w_fall_nxt;
            r_peak_c   <= w_peak_c_nxt;
            r_trough_c <= w_trough_c_nxt;
            r_meas     <= w_publish;
            r_err      <= w_viol;
            if (w_publish) begin
                r_peak       <= r_peak_c;
                r_trough     <= r_trough_c;
                r_rise_len   <= r_rise;
                r_hold_len   <= r_hold;
                r_fall_len   <= r_fall;
                r_period_len <= w_period;
            end
            if (w_viol && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign locked     = (r_state == ST_RISE) || (r_state == ST_HOLD) || (r_state == ST_FALL);
    assign meas_vld   = r_meas;
    assign err        = r_err;
    assign err_cnt    = r_err_cnt;
    assign peak       = r_peak;
    assign trough     = r_trough;
    assign rise_len   = r_rise_len;
    assign hold_len   = r_hold_len;
    assign fall_len   = r_fall_len;
    assign period_len = r_period_len;

endmodule
`default_nettype wire

// File: tb/tb_tri_meas.sv
`default_nettype none
// ============================================================================
// Module      : tb_tri_meas
// Description : Directed self-checking bench for tri_meas.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tri_meas;

    localparam int DW = 9;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          in_vld = 1'b0;
    logic [DW-1:0] d_in = '0;
    logic          locked;
    logic          meas_vld;
    logic [DW-1:0] peak;
    logic [DW-1:0] trough;
    logic [CW-1:0] rise_len;
    logic [CW-1:0] hold_len;
    logic [CW-1:0] fall_len;
    logic [CW-1:0] period_len;
    logic          err;
    logic [7:0]    err_cnt;

    int total = 0;
    int bad   = 0;
    int n_meas = 0;
    int n_err  = 0;
    int cyc    = 0;
    int meas_cyc[$];
    bit gaps   = 1'b0;

    always #5 clk = ~clk;

    tri_meas #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk        (clk),
        .res        (res),
        .in_vld     (in_vld),
        .d_in       (d_in),
        .locked     (locked),
        .meas_vld   (meas_vld),
        .peak       (peak),
        .trough     (trough),
        .rise_len   (rise_len),
        .hold_len   (hold_len),
        .fall_len   (fall_len),
        .period_len (period_len),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    // One clock with the given input; outputs are observed 1 ns after the edge
    task automatic send(input logic v, input int d);
        in_vld = v;
        d_in   = d[DW-1:0];
        @(posedge clk);
        #1;
        cyc++;
        if (meas_vld === 1'b1) begin
            n_meas++;
            meas_cyc.push_back(cyc);
        end
        if (err === 1'b1) n_err++;
    endtask

    // One valid sample, optionally preceded by an idle cycle carrying garbage
    task automatic samp(input int d);
        if (gaps && ($urandom_range(0, 1) == 1)) send(1'b0, int'($urandom_range(0, 511)));
        send(1'b1, d);
    endtask

    task automatic ramp(input int a, input int b);
        if (a <= b) begin
            for (int v = a; v <= b; v++) samp(v);
        end else begin
            for (int v = a; v >= b; v--) samp(v);
        end
    endtask

    task automatic flat(input int v, input int n);
        repeat (n) samp(v);
    endtask

    task automatic do_reset();
        res    = 1'b0;
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        res    = 1'b1;
        n_meas = 0;
        n_err  = 0;
        meas_cyc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({locked, meas_vld, err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {locked, meas_vld, err});
        end
        total++;
        if ({peak, trough, rise_len, hold_len, fall_len, period_len, err_cnt} !== '0) begin
            bad++; $display("FAIL reset_values got peak=%0d trough=%0d rise=%0d hold=%0d fall=%0d per=%0d ecnt=%0d exp all 0",
                            peak, trough, rise_len, hold_len, fall_len, period_len, err_cnt);
        end
    endtask

    // 10->20->10 triangle without hold, two full periods measured
    task automatic test_triangle(input string nm);
        do_reset();
        samp(15);
        ramp(14, 10);
        ramp(11, 20);
        ramp(19, 10);
        samp(11);
        total++;
        if (n_meas !== 1) begin
            bad++; $display("FAIL %s first_meas got=%0d exp=1", nm, n_meas);
        end
        ramp(12, 20);
        ramp(19, 10);
        samp(11);
        total++;
        if (n_meas !== 2 || n_err !== 0) begin
            bad++; $display("FAIL %s counts got meas=%0d err=%0d exp meas=2 err=0", nm, n_meas, n_err);
        end
        total++;
        if ({rise_len, hold_len, fall_len, period_len} !== {16'd10, 16'd0, 16'd10, 16'd20}) begin
            bad++; $display("FAIL %s lens got r=%0d h=%0d f=%0d p=%0d exp 10/0/10/20", nm, rise_len, hold_len, fall_len, period_len);
        end
        total++;
        if (peak !== 9'd20 || trough !== 9'd10 || locked !== 1'b1) begin
            bad++; $display("FAIL %s levels got peak=%0d trough=%0d locked=%b exp 20/10/1", nm, peak, trough, locked);
        end
    endtask

    // +5 jump during RISE, then relock with a trapezoid period
    task automatic test_glitch();
        do_reset();
        samp(15);
        ramp(14, 10);
        ramp(11, 20);
        samp(25);
        total++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            bad++; $display("FAIL glitch_err got err=%b cnt=%0d locked=%b exp 1/1/0", err, err_cnt, locked);
        end
        samp(24);
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL glitch_pulse got err=%b exp 0", err);
        end
        ramp(23, 10);
        ramp(11, 20);
        flat(20, 3);
        ramp(19, 10);
        total++;
        if (n_meas !== 0) begin
            bad++; $display("FAIL glitch_early_meas got=%0d exp=0", n_meas);
        end
        samp(11);
        total++;
        if (n_meas !== 1 || meas_vld !== 1'b1) begin
            bad++; $display("FAIL glitch_relock got meas=%0d vld=%b exp 1/1", n_meas, meas_vld);
        end
        total++;
        if ({rise_len, hold_len, fall_len, period_len, 7'd0, peak, 7'd0, trough} !==
            {16'd10, 16'd3, 16'd10, 16'd23, 7'd0, 9'd20, 7'd0, 9'd10}) begin
            bad++; $display("FAIL glitch_values got r=%0d h=%0d f=%0d p=%0d pk=%0d tr=%0d exp 10/3/10/23/20/10",
                            rise_len, hold_len, fall_len, period_len, peak, trough);
        end
    endtask

    // FLAT in FALL, UP in HOLD, then drive the error counter into saturation
    task automatic test_illegal();
        do_reset();
        samp(15);
        ramp(14, 10);
        ramp(11, 13);
        samp(13);
        samp(12);
        samp(12);
        total++;
        if (err !== 1'b1 || err_cnt !== 8'd1) begin
            bad++; $display("FAIL flat_in_fall got err=%b cnt=%0d exp 1/1", err, err_cnt);
        end
        samp(11);
        samp(12);
        samp(12);
        samp(13);
        total++;
        if (err !== 1'b1 || err_cnt !== 8'd2 || n_meas !== 0) begin
            bad++; $display("FAIL up_in_hold got err=%b cnt=%0d meas=%0d exp 1/2/0", err, err_cnt, n_meas);
        end
        for (int i = 0; i < 260; i++) begin
            if ((i % 2) == 0) begin
                samp(12); samp(13); samp(18);
            end else begin
                samp(17); samp(18); samp(13);
            end
        end
        total++;
        if (err_cnt !== 8'd255 || n_err !== 262) begin
            bad++; $display("FAIL err_sat got cnt=%0d pulses=%0d exp 255/262", err_cnt, n_err);
        end
        total++;
        if (err !== 1'b1 || {peak, rise_len, period_len} !== '0) begin
            bad++; $display("FAIL err_retain got err=%b pk=%0d r=%0d p=%0d exp 1/0/0/0", err, peak, rise_len, period_len);
        end
    endtask

    // Synchronous reset while in HOLD after one published period
    task automatic test_reset_mid_hold();
        do_reset();
        samp(15);
        samp(14);
        samp(15);
        samp(20);
        ramp(19, 10);
        ramp(11, 20);
        ramp(19, 10);
        samp(11);
        ramp(12, 20);
        flat(20, 2);
        total++;
        if (n_meas !== 1 || err_cnt !== 8'd1 || period_len !== 16'd20) begin
            bad++; $display("FAIL pre_reset got meas=%0d cnt=%0d per=%0d exp 1/1/20", n_meas, err_cnt, period_len);
        end
        res    = 1'b0;
        in_vld = 1'b1;
        d_in   = 9'd20;
        @(posedge clk);
        #1;
        res = 1'b1;
        total++;
        if ({locked, meas_vld, err, peak, trough, rise_len, hold_len, fall_len, period_len, err_cnt} !== '0) begin
            bad++; $display("FAIL mid_hold_reset got lk=%b pk=%0d tr=%0d r=%0d h=%0d f=%0d p=%0d cnt=%0d exp all 0",
                            locked, peak, trough, rise_len, hold_len, fall_len, period_len, err_cnt);
        end
        n_meas = 0;
        samp(20);
        ramp(19, 10);
        ramp(11, 20);
        ramp(19, 10);
        total++;
        if (n_meas !== 0 || period_len !== 16'd0) begin
            bad++; $display("FAIL post_reset_early got meas=%0d per=%0d exp 0/0", n_meas, period_len);
        end
        samp(11);
        total++;
        if (n_meas !== 1 || period_len !== 16'd20 || rise_len !== 16'd10) begin
            bad++; $display("FAIL post_reset_meas got meas=%0d per=%0d rise=%0d exp 1/20/10", n_meas, period_len, rise_len);
        end
    endtask

    // Generator pattern 0->300, 201 held samples, 300->0, continuous valid
    task automatic test_generator();
        do_reset();
        for (int p = 0; p < 4; p++) begin
            ramp(0, 300);
            flat(300, 201);
            ramp(299, 1);
        end
        samp(0);
        samp(1);
        total++;
        if (n_meas !== 3 || n_err !== 0) begin
            bad++; $display("FAIL gen_counts got meas=%0d err=%0d exp 3/0", n_meas, n_err);
        end
        total++;
        if (meas_cyc.size() != 3 || (meas_cyc[1] - meas_cyc[0]) !== 801 || (meas_cyc[2] - meas_cyc[1]) !== 801) begin
            bad++; $display("FAIL gen_interval got n=%0d exp 3 pulses 801 apart", meas_cyc.size());
        end
        total++;
        if ({rise_len, hold_len, fall_len, period_len} !== {16'd300, 16'd201, 16'd300, 16'd801}) begin
            bad++; $display("FAIL gen_lens got r=%0d h=%0d f=%0d p=%0d exp 300/201/300/801", rise_len, hold_len, fall_len, period_len);
        end
        total++;
        if (peak !== 9'd300 || trough !== 9'd0) begin
            bad++; $display("FAIL gen_levels got peak=%0d trough=%0d exp 300/0", peak, trough);
        end
    endtask

    // 511 -> 0 must not count as an upward step
    task automatic test_wrap();
        do_reset();
        samp(100);
        samp(99);
        ramp(100, 511);
        samp(0);
        total++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            bad++; $display("FAIL wrap got err=%b cnt=%0d locked=%b exp 1/1/0", err, err_cnt, locked);
        end
    endtask

    initial begin
        test_reset();
        gaps = 1'b0;
        test_triangle("triangle");
        gaps = 1'b1;
        test_triangle("gaps");
        gaps = 1'b0;
        test_glitch();
        test_illegal();
        test_reset_mid_hold();
        test_wrap();
        test_generator();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
